// File: rtl/shift_unit_seq_if.sv
// Handshake bundle for the sequential shifter: operand side (in_*), result
// side (out_*) and a busy flag. master drives operands, slave is the shifter.
interface shift_unit_seq_if #(
   parameter int XLEN = 32
) ();
   localparam int SHW = $clog2(XLEN);

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [SHW-1:0]  amount;
   logic            right;
   logic            arth;
   logic            rot;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, a, amount, right, arth, rot, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, a, amount, right, arth, rot, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/shift_unit_seq.sv
// Iterative shifter: SLL/SRL/SRA/ROL/ROR on an XLEN-bit operand, moving at
// most STEP bits per cycle. IDLE accepts an operand, SHIFT walks the
// remaining distance down, DONE holds the result until the consumer takes it.
module shift_unit_seq #(
   parameter  int XLEN = 32,
   parameter  int STEP = 1,
   localparam int SHW  = $clog2(XLEN)
) (
   input logic              clk,
   input logic              rst,
   shift_unit_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [SHW-1:0] STEP_V = SHW'(STEP);

   state_t          state;
   logic [XLEN-1:0] acc;
   logic [SHW-1:0]  rem;
   logic            m_right;
   logic            m_arth;
   logic            m_rot;
   logic [SHW-1:0]  k;

   // One partial shift of v by n bits; the fill always comes from v itself,
   // so SRA keeps re-reading the unchanged sign bit on every step.
   function automatic logic [XLEN-1:0] shift_op(
      input logic [XLEN-1:0] v,
      input logic [SHW-1:0]  n,
      input logic            r,
      input logic            ar,
      input logic            ro
   );
      logic [2*XLEN-1:0] dbl;
      logic [XLEN-1:0]   res;
      dbl = {v, v};
      if (ro && r) begin
         dbl = dbl >> n;
         res = dbl[XLEN-1:0];
      end else if (ro) begin
         dbl = dbl << n;
         res = dbl[2*XLEN-1:XLEN];
      end else if (r && ar) begin
         res = XLEN'($signed(v) >>> n);
      end else if (r) begin
         res = v >> n;
      end else begin
         res = v << n;
      end
      return res;
   endfunction

   // Step size for this cycle: the full STEP, or the leftover tail.
   always_comb begin
      k = (rem < STEP_V) ? rem : STEP_V;
   end

   // Control FSM together with the accumulator, remaining count and mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         rem     <= '0;
         m_right <= 1'b0;
         m_arth  <= 1'b0;
         m_rot   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc     <= bus.a;
                  rem     <= bus.amount;
                  m_right <= bus.right;
                  m_arth  <= bus.arth;
                  m_rot   <= bus.rot;
                  state   <= (bus.amount == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               acc   <= shift_op(acc, k, m_right, m_arth, m_rot);
               rem   <= rem - k;
               state <= (rem == k) ? DONE : SHIFT;
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status outputs decode straight from the state register; in_ready is
   // also forced low while reset is asserted.
   assign bus.in_ready  = (state == IDLE) & ~rst;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.result    = acc;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: three instances (STEP = 1, 4, 8) share stimulus;
// sel picks which one receives in_valid and whose outputs are observed.
module tb_shift_unit_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   int           sel = 0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [31:0]  a = '0;
   logic [4:0]   amount = '0;
   logic         right = 1'b0;
   logic         arth = 1'b0;
   logic         rot = 1'b0;

   shift_unit_seq_if #(.XLEN(32)) if0 ();
   shift_unit_seq_if #(.XLEN(32)) if1 ();
   shift_unit_seq_if #(.XLEN(32)) if2 ();

   assign if0.in_valid = in_valid & (sel == 0);
   assign if1.in_valid = in_valid & (sel == 1);
   assign if2.in_valid = in_valid & (sel == 2);
   assign if0.out_ready = out_ready;
   assign if1.out_ready = out_ready;
   assign if2.out_ready = out_ready;
   assign if0.a = a;  assign if1.a = a;  assign if2.a = a;
   assign if0.amount = amount;  assign if1.amount = amount;  assign if2.amount = amount;
   assign if0.right = right;  assign if1.right = right;  assign if2.right = right;
   assign if0.arth = arth;  assign if1.arth = arth;  assign if2.arth = arth;
   assign if0.rot = rot;  assign if1.rot = rot;  assign if2.rot = rot;

   shift_unit_seq #(.XLEN(32), .STEP(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   shift_unit_seq #(.XLEN(32), .STEP(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   shift_unit_seq #(.XLEN(32), .STEP(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   logic        in_ready_m;
   logic        out_valid_m;
   logic        busy_m;
   logic [31:0] result_m;

   always_comb begin
      case (sel)
         1: begin
            in_ready_m = if1.in_ready; out_valid_m = if1.out_valid;
            busy_m = if1.busy; result_m = if1.result;
         end
         2: begin
            in_ready_m = if2.in_ready; out_valid_m = if2.out_valid;
            busy_m = if2.busy; result_m = if2.result;
         end
         default: begin
            in_ready_m = if0.in_ready; out_valid_m = if0.out_valid;
            busy_m = if0.busy; result_m = if0.result;
         end
      endcase
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: the whole operation in one go, from the mode rules.
   function automatic logic [31:0] model(input logic [31:0] v, input int amt,
                                         input bit r, input bit ar, input bit ro);
      logic [31:0] ones;
      logic [31:0] fill;
      ones = 32'hFFFF_FFFF;
      if (ro) begin
         if (r) return (v >> amt) | (v << (32 - amt));
         else   return (v << amt) | (v >> (32 - amt));
      end
      if (!r) return v << amt;
      fill = (ar && v[31]) ? ~(ones >> amt) : 32'h0;
      return (v >> amt) | fill;
   endfunction

   function automatic int steps(input int amt, input int s);
      int st;
      st = (s == 0) ? 1 : (s == 1) ? 4 : 8;
      return (amt + st - 1) / st;
   endfunction

   // Issue one operation, check latency/result, optionally hold off the
   // consumer for 'hold' cycles, then retire it.
   task automatic run_op(input int s, input logic [31:0] av, input int amt,
                         input bit r, input bit ar, input bit ro,
                         input logic [31:0] exp, input int explat,
                         input int hold, input string nm);
      int          waitc;
      int          lat;
      bit          ok;
      logic [31:0] held;
      sel = s;
      @(negedge clk);
      waitc = 0;
      while (!in_ready_m && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      chk({nm, "_in_ready"}, {31'b0, in_ready_m}, 32'd1);
      a = av; amount = 5'(amt); right = r; arth = ar; rot = ro;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; amount = 5'($urandom); right = 1'($urandom);
      arth = 1'($urandom); rot = 1'($urandom);
      lat = 0;
      ok = 1'b1;
      while (!out_valid_m && lat < 40) begin
         if (!busy_m || in_ready_m) ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({nm, "_busy"}, {31'b0, ok & busy_m}, 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(explat));
      chk({nm, "_result"}, result_m, exp);
      if (hold > 0) begin
         held = result_m;
         ok = 1'b1;
         for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            a = $urandom; amount = 5'($urandom);
            @(negedge clk);
            if (!out_valid_m || result_m !== held || in_ready_m || !busy_m) ok = 1'b0;
         end
         in_valid = 1'b0;
         chk({nm, "_hold"}, {31'b0, ok}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_retire_valid"}, {31'b0, out_valid_m}, 32'd0);
      chk({nm, "_retire_ready"}, {31'b0, in_ready_m}, 32'd1);
   endtask

   typedef struct {
      int          s;
      logic [31:0] av;
      int          amt;
      bit          r;
      bit          ar;
      bit          ro;
      logic [31:0] exp;
      int          lat;
      int          hold;
   } vec_t;

   vec_t tbl[13];

   initial begin
      // sel, a, amount, right, arth, rot, expected, latency, hold
      tbl[0]  = '{0, 32'h0000_0001, 31, 0, 0, 0, 32'h8000_0000, 31, 0};
      tbl[1]  = '{1, 32'h8000_00F0,  4, 1, 1, 0, 32'hF800_000F,  1, 0};
      tbl[2]  = '{1, 32'h8000_00F0,  4, 1, 0, 0, 32'h0800_000F,  1, 0};
      tbl[3]  = '{2, 32'h1234_5678,  8, 1, 0, 1, 32'h7812_3456,  1, 0};
      tbl[4]  = '{2, 32'h1234_5678,  8, 0, 0, 1, 32'h3456_7812,  1, 0};
      tbl[5]  = '{2, 32'h8000_0000, 31, 1, 0, 0, 32'h0000_0001,  4, 0};
      tbl[6]  = '{2, 32'hDEAD_BEEF,  0, 1, 1, 0, 32'hDEAD_BEEF,  0, 0};
      tbl[7]  = '{0, 32'hDEAD_BEEF,  0, 1, 0, 1, 32'hDEAD_BEEF,  0, 0};
      tbl[8]  = '{1, 32'h8000_0001,  5, 0, 0, 1, 32'h0000_0030,  2, 0};
      tbl[9]  = '{1, 32'h8000_0000, 31, 1, 1, 0, 32'hFFFF_FFFF,  8, 0};
      tbl[10] = '{2, 32'hFFFF_FFFF, 13, 0, 0, 0, 32'hFFFF_E000,  2, 0};
      tbl[11] = '{2, 32'h8000_0000,  8, 1, 0, 0, 32'h0080_0000,  1, 5};
      tbl[12] = '{2, 32'h0000_1234,  4, 0, 0, 0, 32'h0001_2340,  1, 0};

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #2;
      chk("reset_in_ready", {31'b0, in_ready_m}, 32'd0);
      chk("reset_out_valid", {31'b0, out_valid_m}, 32'd0);
      chk("reset_busy", {31'b0, busy_m}, 32'd0);
      chk("reset_result", result_m, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_op(tbl[i].s, tbl[i].av, tbl[i].amt, tbl[i].r, tbl[i].ar, tbl[i].ro,
                tbl[i].exp, tbl[i].lat, tbl[i].hold, $sformatf("vec%0d", i));
      end

      // Reset pulse mid-cycle during cycle 3 of a long STEP=1 operation.
      sel = 0;
      @(negedge clk);
      a = 32'hFFFF_FFFF; amount = 5'd31; right = 1'b0; arth = 1'b0; rot = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid_m}, 32'd0);
      chk("midrst_busy", {31'b0, busy_m}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready_m}, 32'd0);
      chk("midrst_result", result_m, 32'h0);
      #1 rst = 1'b0;
      run_op(0, 32'h0000_0003, 2, 0, 0, 0, 32'h0000_000C, 2, 0, "post_reset");

      // Randomized operations against the reference model.
      for (int i = 0; i < 50; i++) begin
         int          s;
         logic [31:0] av;
         int          amt;
         bit          r, ar, ro;
         s   = int'($urandom_range(0, 2));
         av  = $urandom;
         amt = int'($urandom_range(0, 31));
         r   = 1'($urandom);
         ar  = 1'($urandom);
         ro  = 1'($urandom);
         run_op(s, av, amt, r, ar, ro, model(av, amt, r, ar, ro), steps(amt, s),
                ($urandom_range(0, 3) == 0) ? 2 : 0, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Sequential, parametrised shifter for the RV32I ALU path and its wider derivatives. It performs logical left, logical right, arithmetic right, rotate-left and rotate-right on an XLEN-bit operand. The shift runs iteratively at up to STEP bits per cycle, which trades latency for area against the single-cycle combinational shifter. Operands enter through a valid/ready handshake and results leave through another; the block sits between the issue stage and the ALU result mux.

## Interface
- XLEN, 32, operand/result width; power of two, 8..64
- STEP, 1, maximum bits shifted per cycle; power of two, 1..XLEN/2
- SHW, log2(XLEN), derived width of the shift amount; not overridden
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept; equals (state==IDLE) & ~rst
- a  input  XLEN  operand
- amount  input  SHW  shift distance, 0..XLEN-1
- right  input  1  0 = left, 1 = right
- arth  input  1  arithmetic fill; honoured only when right=1 and rot=0
- rot  input  1  rotate instead of shift; arth ignored
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  shifted value
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE. Registers: acc[XLEN], rem[SHW], mode {right, arth, rot}.
- IDLE: a transfer occurs when in_valid & in_ready.
  - On transfer: acc←a, rem←amount, mode←{right, arth, rot}.
  - Next state is DONE if amount==0, else SHIFT.
  - in_valid while not IDLE is ignored; the upstream holds its data.
- SHIFT: each cycle k = min(rem, STEP).
  - acc←op(acc, k) and rem←rem−k.
  - Next state is DONE when rem−k==0, else SHIFT.
- op(acc, k), where the fill source is acc itself:
  - SLL (right=0, rot=0): zero fill from LSB.
  - SRL (right=1, arth=0, rot=0): zero fill from MSB.
  - SRA (right=1, arth=1, rot=0): replicate acc[XLEN−1].
  - ROL (right=0, rot=1): bits leaving the MSB re-enter at the LSB.
  - ROR (right=1, rot=1): bits leaving the LSB re-enter at the MSB.
- Final result equals the single-step operation by `amount`. SRA preserves the sign of the original `a` because the MSB never changes.
- DONE: out_valid=1 and result=acc.
  - On out_ready: next state is IDLE.
  - While out_ready=0, result, out_valid and all state are held unchanged.
- result is driven from acc in every state. It is only meaningful while out_valid=1.
- The stored mode is used throughout an operation. Changes on right/arth/rot/a/amount after acceptance have no effect.

## Timing
- Reset (async assert, any state):
  - Immediately: state=IDLE, acc=0, rem=0, mode=0, out_valid=0, busy=0, in_ready=0 while rst=1.
  - An in-flight operation is discarded with no output.
  - After deassertion: in_ready=1 on the first clock; the first transfer may occur on the first rising edge after deassertion.
- Latency: with the accepting edge counted as edge 0, out_valid is high after edge N = ceil(amount/STEP).
  - amount=0 gives N=0, so out_valid is high in the cycle right after acceptance.
- Throughput: one operation per N+2 cycles minimum (accept, N shift cycles, DONE handshake, IDLE).
  - No acceptance in the DONE→IDLE cycle; in_ready rises the cycle after out_ready is taken.
- Last partial step: when amount is not a multiple of STEP, the final SHIFT cycle shifts by amount mod STEP.
- No combinational path from in_valid or out_ready to any output except through state registers.

## Test plan
- XLEN=32, STEP=1, SLL, a=0x00000001, amount=31 → result 0x80000000; out_valid after edge 31; busy high throughout.
- STEP=4, SRA, a=0x800000F0, amount=4 → result 0xF800000F, N=1. Same a with SRL → 0x0800000F.
- STEP=8, ROR, a=0x12345678, amount=8 → 0x78123456. ROL, amount=8 → 0x34567812. SRL, a=0x80000000, amount=31 → 0x00000001, N=4 (steps 8, 8, 8, 7).
- amount=0, any mode, a=0xDEADBEEF → result 0xDEADBEEF in the cycle after acceptance. Change right/arth/rot/a after acceptance on a nonzero op → no effect.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new data → result and out_valid stable, in_ready=0, new data not taken. Then out_ready=1 → IDLE next cycle, new data accepted after that.
- Async rst pulse mid-cycle during cycle 3 of an STEP=1, amount=31 op → out_valid=0 and busy=0 without a clock edge. Next op SLL a=0x3, amount=2 → 0xC.
